dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests. Requests are accepted over a valid/ready handshake and answered with a single-cycle response pulse after a fixed latency. While a request is in flight, `busy` stalls the pipeline. This block replaces the single-cycle data memory.

## Interface

**Parameters**
- `DEPTH_WORDS`, default 512: number of 64-bit doublewords of storage. Byte capacity is `DEPTH_WORDS*8`.
- `LATENCY`, default 2: cycles from the acceptance cycle to the response cycle. Legal range 1..15.

**Ports** (one clock; reset is asynchronous and active-low)
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present. Held stable by the requester until `resp_valid`.
- `req_ready` out 1: responder can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 64: byte address.
- `req_size` in 2: access size. 0 = byte, 1 = half, 2 = word, 3 = doubleword.
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `req_wdata` in 64: store data. The low `8<<req_size` bits are used.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 64: load result. Zero for stores and errors.
- `resp_err` out 1: request was misaligned or out of range. Valid while `resp_valid` is high.
- `busy` out 1: pipeline stall request.

## Operation

**States**
- IDLE
  - `req_ready`=1.
  - `req_valid`=1 → accept and capture all `req_*` fields.
  - Go to RESP if `LATENCY`==1, otherwise to WAIT with the counter loaded to `LATENCY-2`.
- WAIT
  - `req_ready`=0.
  - Counter decrements each cycle.
  - At count 0 → RESP.
- RESP
  - `resp_valid`=1 for exactly one cycle, `req_ready`=0.
  - Next state is always IDLE.

**Busy**
- `busy` = (IDLE and `req_valid`) or WAIT.
- `busy`=0 in RESP, so the pipeline advances on the response cycle.

**Error check** (evaluated on captured fields)
- Misaligned: `addr mod (1<<size)` ≠ 0.
- Out of range: `addr >= DEPTH_WORDS*8`.
- On error: no array write, `resp_rdata`=0, `resp_err`=1.

**Addressing and data layout**
- Word index = `addr[..:3]`; byte lane = `addr[2:0]`. Little-endian.
- Stores: byte-enable merge of the low `8<<size` bits into the addressed lanes. Other lanes are unchanged.
- Loads: extract the lanes, then zero- or sign-extend to 64 bits per `req_unsigned`. For doublewords `req_unsigned` is ignored.

**Commit point**
- Store write and load read both occur at the clock edge that enters RESP.
- `resp_rdata` and `resp_err` are registered at that edge and held until the next response.
- A load accepted after a store observes the store's data.

**Reset**
- Asynchronous.
- State → IDLE, counter → 0.
- `resp_valid`=0, `resp_rdata`=0, `resp_err`=0. `req_ready`=1 after release, and `busy` follows `req_valid`.
- Reset mid-WAIT abandons the request: no write, no response.
- The storage array is NOT cleared by reset.

## Timing

- Acceptance occurs in cycle c (IDLE with `req_valid`=1). `resp_valid` is high in cycle c+`LATENCY`.
- Back-to-back throughput: one request per `LATENCY`+1 cycles. The IDLE cycle is mandatory after RESP.
- A requester that keeps `req_valid` high in the cycle after RESP issues a new request, which is accepted in that cycle.
- `req_*` changes during WAIT/RESP have no effect; fields are captured at acceptance.
- `resp_rdata`/`resp_err` hold their last values after `resp_valid` falls.
- Counter width is 4 bits. `LATENCY`=1 never uses WAIT.
- Reset asserted while in RESP: `resp_valid` clears immediately (asynchronously). A store whose commit edge already occurred remains written.

## Test plan

1. Reset with `LATENCY`=2, `reset_n` low → all outputs 0.
   - After release, with `req_valid`=0: `req_ready`=1, `busy`=0.
2. Store doubleword `0x1122334455667788` at address 0x40, then load doubleword at 0x40.
   - Load `resp_rdata` = `0x1122334455667788`.
   - Each `resp_valid` arrives exactly 2 cycles after acceptance.
   - `busy`=1 in the acceptance and WAIT cycles, 0 in RESP.
3. Store byte `0x80` at 0x43, then load byte at 0x43 signed and unsigned.
   - Signed → `0xFFFFFFFFFFFFFF80`; unsigned → `0x80`.
   - Doubleword at 0x40 becomes `0x1122334480667788`.
4. Load word at 0x42 → `resp_err`=1, `resp_rdata`=0.
   - Store half at address `DEPTH_WORDS*8` → `resp_err`=1, and memory is unchanged (verified by read-back).
5. `LATENCY`=1 build with continuous `req_valid` → accept every 2 cycles, `resp_valid` in the cycle after each acceptance.
   - `LATENCY`=4 build → response 4 cycles after acceptance.
6. Assert `reset_n` during WAIT of a store of `0xDEAD` to 0x80.
   - No `resp_valid` is produced.
   - A subsequent load at 0x80 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data memory for MEM-stage loads/stores; response pulse LATENCY cycles after acceptance.
// One request in flight: req_ready only in IDLE, busy stalls the pipeline until the response cycle.
module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] BYTE_CAP = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [63:0] mem [DEPTH_WORDS];

  // With LATENCY==1 the commit edge is the acceptance edge, so the live request
  // fields stand in for the not-yet-captured ones.
  logic        f_write, f_uns;
  logic [63:0] f_addr, f_wdata;
  logic [1:0]  f_size;

  logic              commit, misaligned, err;
  logic [IDX_W-1:0]  idx;
  logic [5:0]        sh;
  logic [63:0]       size_mask, lane_mask, cur_word, merged, shifted, load_val;

  always_comb begin
    if (state_q == S_IDLE) begin
      f_write = req_write;
      f_addr  = req_addr;
      f_size  = req_size;
      f_uns   = req_unsigned;
      f_wdata = req_wdata;
    end else begin
      f_write = write_q;
      f_addr  = addr_q;
      f_size  = size_q;
      f_uns   = uns_q;
      f_wdata = wdata_q;
    end
  end

  always_comb begin
    case (f_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = f_addr[0];
      2'd2:    misaligned = |f_addr[1:0];
      default: misaligned = |f_addr[2:0];
    endcase
    err = misaligned || (f_addr >= BYTE_CAP);
  end

  always_comb begin
    idx = f_addr[IDX_W+2:3];
    sh  = {f_addr[2:0], 3'b000};
    case (f_size)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
    lane_mask = size_mask << sh;
    cur_word  = mem[idx];
    merged    = (cur_word & ~lane_mask) | ((f_wdata << sh) & lane_mask);
    shifted   = cur_word >> sh;
    case (f_size)
      2'd0:    load_val = f_uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    load_val = f_uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_val = f_uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  assign commit = ((state_q == S_IDLE) && req_valid && (LATENCY == 1)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd0));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      resp_valid_d = 1'b1;
      resp_err_d   = err;
      resp_rdata_d = (err || f_write) ? 64'd0 : load_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 64'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      wdata_q      <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is deliberately not reset; a write is blocked while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && commit && f_write && !err) mem[idx] <= merged;
  end

  assign req_ready  = reset_n && (state_q == S_IDLE);
  assign busy       = ((state_q == S_IDLE) && req_valid) || (state_q == S_WAIT);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of load/store vectors with a response scoreboard,
// plus reset-abort, reset-in-response and LATENCY=1/4 timing sequences.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, req_valid, req_write, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [63:0] resp_rdata;

  logic        v1, v4;
  logic        r1_ready, r1_valid, r1_err, r1_busy;
  logic        r4_ready, r4_valid, r4_err, r4_busy;
  logic [63:0] r1_rdata, r4_rdata;

  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_ready(r1_ready),
    .req_write(1'b1), .req_addr(64'h8), .req_size(2'd3),
    .req_unsigned(1'b0), .req_wdata(64'h1), .resp_valid(r1_valid),
    .resp_rdata(r1_rdata), .resp_err(r1_err), .busy(r1_busy)
  );

  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .req_valid(v4), .req_ready(r4_ready),
    .req_write(1'b1), .req_addr(64'h8), .req_size(2'd3),
    .req_unsigned(1'b0), .req_wdata(64'h1), .resp_valid(r4_valid),
    .resp_rdata(r4_rdata), .resp_err(r4_err), .busy(r4_busy)
  );

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                              input logic uns, input logic [63:0] wdata,
                              input logic [63:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_addr     = v.addr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_wdata    = v.wdata;
  endtask

  // Issue one request in an IDLE cycle, then follow it to its response.
  task automatic do_req(input string name, input vec_t v);
    int   lat;
    bit   got;
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    check({name, "_ready"}, 64'(req_ready), 64'd1);
    check({name, "_busy_acc"}, 64'(busy), 64'd1);
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        got = 1'b1;
        e = sb.pop_front();
        check({name, "_lat"}, 64'(lat), 64'd2);
        check({name, "_busy_resp"}, 64'(busy), 64'd0);
        check({name, "_rdata"}, resp_rdata, e.rdata);
        check({name, "_err"}, 64'(resp_err), 64'(e.err));
      end else begin
        check({name, "_busy_wait"}, 64'(busy), 64'd1);
      end
    end
    check({name, "_timeout"}, 64'(got), 64'd1);
    req_valid = 1'b0;
  endtask

  vec_t vecs[19];
  int   pulses;
  bit   got;

  initial begin
    vecs[0]  = mk(1, 64'h0,    2'd3, 0, 64'h0123456789ABCDEF, 64'h0, 0);
    vecs[1]  = mk(1, 64'h40,   2'd3, 0, 64'h1122334455667788, 64'h0, 0);
    vecs[2]  = mk(0, 64'h40,   2'd3, 0, 64'h0, 64'h1122334455667788, 0);
    vecs[3]  = mk(1, 64'h43,   2'd0, 0, 64'hAAAAAAAAAAAAAA80, 64'h0, 0);
    vecs[4]  = mk(0, 64'h43,   2'd0, 0, 64'h0, 64'hFFFFFFFFFFFFFF80, 0);
    vecs[5]  = mk(0, 64'h43,   2'd0, 1, 64'h0, 64'h0000000000000080, 0);
    vecs[6]  = mk(0, 64'h40,   2'd3, 0, 64'h0, 64'h1122334480667788, 0);
    vecs[7]  = mk(0, 64'h42,   2'd2, 0, 64'h0, 64'h0, 1);
    vecs[8]  = mk(1, 64'h1000, 2'd1, 0, 64'hBEEF, 64'h0, 1);
    vecs[9]  = mk(0, 64'h0,    2'd3, 0, 64'h0, 64'h0123456789ABCDEF, 0);
    vecs[10] = mk(0, 64'h40,   2'd3, 0, 64'h0, 64'h1122334480667788, 0);
    vecs[11] = mk(1, 64'h46,   2'd1, 0, 64'h555555555555F234, 64'h0, 0);
    vecs[12] = mk(0, 64'h46,   2'd1, 0, 64'h0, 64'hFFFFFFFFFFFFF234, 0);
    vecs[13] = mk(0, 64'h46,   2'd1, 1, 64'h0, 64'h000000000000F234, 0);
    vecs[14] = mk(0, 64'h40,   2'd3, 1, 64'h0, 64'hF234334480667788, 0);
    vecs[15] = mk(0, 64'h41,   2'd1, 0, 64'h0, 64'h0, 1);
    vecs[16] = mk(0, 64'h44,   2'd2, 0, 64'h0, 64'hFFFFFFFFF2343344, 0);
    vecs[17] = mk(1, 64'hFF8,  2'd3, 0, 64'h0F0E0D0C0B0A0908, 64'h0, 0);
    vecs[18] = mk(0, 64'hFFF,  2'd0, 1, 64'h0, 64'h000000000000000F, 0);

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_unsigned = 1'b0; req_wdata = '0; v1 = 1'b0; v4 = 1'b0;
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 19; i++) do_req($sformatf("v%0d", i), vecs[i]);

    // Reset during WAIT abandons the store.
    do_req("pre80", mk(1, 64'h80, 2'd3, 0, 64'h5555666677778888, 64'h0, 0));
    @(negedge clk);
    drive(mk(1, 64'h80, 2'd1, 0, 64'hDEAD, 64'h0, 0));
    @(negedge clk);
    #1;
    check("abort_busy_wait", 64'(busy), 64'd1);
    reset_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort_no_resp", 64'(pulses), 64'd0);
    do_req("abort_readback", mk(0, 64'h80, 2'd3, 0, 64'h0, 64'h5555666677778888, 0));

    // Reset during RESP drops the pulse at once but keeps the committed store.
    @(negedge clk);
    drive(mk(1, 64'h88, 2'd3, 0, 64'h0BADF00D0BADF00D, 64'h0, 0));
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    check("rresp_seen", 64'(got), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rresp_async_clear", 64'(resp_valid), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_req("rresp_readback", mk(0, 64'h88, 2'd3, 0, 64'h0, 64'h0BADF00D0BADF00D, 0));

    // Continuous requests on the LATENCY=1 and LATENCY=4 builds.
    @(negedge clk);
    v1 = 1'b1;
    v4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("l1_ready_c%0d", i), 64'(r1_ready), 64'((i % 2) == 0));
      check($sformatf("l1_resp_c%0d", i),  64'(r1_valid), 64'((i % 2) == 1));
      check($sformatf("l4_ready_c%0d", i), 64'(r4_ready), 64'((i % 5) == 0));
      check($sformatf("l4_resp_c%0d", i),  64'(r4_valid), 64'((i % 5) == 4));
      @(negedge clk);
    end
    v1 = 1'b0;
    v4 = 1'b0;

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
